// File: rtl/mdu_seq.sv
// mdu_seq: iterative multiply/divide sequencer owning HI/LO.
// One shared 33-bit adder does a 32-step shift-add multiply or a restoring
// divide, then a single sign-fix cycle writes HI/LO.
// Optional build macro: MDU_FAST_MULT_EN (single-cycle 32x32 multiply).
// Ports:
//   clk, reset_n      clock, async active-low reset
//   start, op[2:0]    launch: 0 mult 1 multu 2 div 3 divu 4 mthi 5 mtlo
//   srcA, srcB        operands (srcA is also the mthi/mtlo data)
//   cancel            flush the in-flight operation
//   busy              an operation is in progress
//   done              one-cycle pulse after HI/LO are written by mult/div
//   hi, lo            the HI/LO registers
module mdu_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [2:0] OP_MULT = 3'd0;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] p_q, p_d;      // multiply P / divide remainder R
    logic [31:0] q_q, q_d;      // multiply Q / divide quotient Q
    logic [31:0] b_q, b_d;      // multiplicand or divisor magnitude
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        isdiv_q, isdiv_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q;
    logic        done_q, done_d;

    logic        signed_op;
    logic        sgn_a, sgn_b;
    logic [31:0] mag_a, mag_b;
    logic        div_by_zero;

    logic [32:0] add_a, add_b;
    logic [33:0] sum;
    logic [32:0] mstep;
    logic [63:0] prod, prod_fix;
    logic [31:0] quot_fix, rem_fix;

    assign signed_op   = (op == OP_MULT) || (op == OP_DIV);
    assign sgn_a       = signed_op & srcA[31];
    assign sgn_b       = signed_op & srcB[31];
    assign mag_a       = sgn_a ? (32'd0 - srcA) : srcA;
    assign mag_b       = sgn_b ? (32'd0 - srcB) : srcB;
    assign div_by_zero = op[1] && (srcB == 32'd0);

    // Shared adder: P+M for multiply, {R,Q[31]}-D for divide.
    // For divide, sum[33] is the no-borrow flag (difference >= 0).
    assign add_a = isdiv_q ? {p_q, q_q[31]} : {1'b0, p_q};
    assign add_b = isdiv_q ? ~{1'b0, b_q} : {1'b0, b_q};
    assign sum   = {1'b0, add_a} + {1'b0, add_b} + {33'd0, isdiv_q};

    assign mstep = q_q[0] ? sum[32:0] : {1'b0, p_q};

    assign prod     = {p_q, q_q};
    assign prod_fix = qneg_q ? (64'd0 - prod) : prod;
    assign quot_fix = qneg_q ? (32'd0 - q_q) : q_q;
    assign rem_fix  = rneg_q ? (32'd0 - p_q) : p_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        q_d     = q_q;
        b_d     = b_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        isdiv_d = isdiv_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start && !cancel) begin
                    if (op == OP_MTHI) begin
                        hi_d = srcA;
                    end else if (op == OP_MTLO) begin
                        lo_d = srcA;
                    end else if (!op[2] && !div_by_zero) begin
                        cnt_d   = 5'd0;
                        b_d     = mag_b;
                        isdiv_d = op[1];
                        qneg_d  = sgn_a ^ sgn_b;
                        rneg_d  = sgn_a;
`ifdef MDU_FAST_MULT_EN
                        if (op[1]) begin
                            p_d     = 32'd0;
                            q_d     = mag_a;
                            state_d = S_RUN;
                        end else begin
                            {p_d, q_d} = {32'd0, mag_a} * {32'd0, mag_b};
                            state_d    = S_FIX;
                        end
`else
                        p_d     = 32'd0;
                        q_d     = mag_a;
                        state_d = S_RUN;
`endif
                    end
                end
            end
            S_RUN: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    if (isdiv_q) begin
                        if (sum[33]) begin
                            p_d = sum[31:0];
                            q_d = {q_q[30:0], 1'b1};
                        end else begin
                            p_d = {p_q[30:0], q_q[31]};
                            q_d = {q_q[30:0], 1'b0};
                        end
                    end else begin
                        p_d = mstep[32:1];
                        q_d = {mstep[0], q_q[31:1]};
                    end
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (isdiv_q) begin
                        lo_d = quot_fix;
                        hi_d = rem_fix;
                    end else begin
                        hi_d = prod_fix[63:32];
                        lo_d = prod_fix[31:0];
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            p_q     <= 32'd0;
            q_q     <= 32'd0;
            b_q     <= 32'd0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            isdiv_q <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            q_q     <= q_d;
            b_q     <= b_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            isdiv_q <= isdiv_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Iterative multiply/divide sequencer for the EX stage of the pipelined CPU. It owns the HI/LO registers and sequences a 32-step shift-add multiply or restoring divide on one shared 33-bit adder. It raises `busy` so the hazard unit stalls any later MDU instruction. The plain ALU handles every single-cycle operation; this block handles only mult/multu/div/divu/mthi/mtlo and the HI/LO reads.

## Interface

- No parameters; data width is fixed at 32.
- `clk  in  1` — the single clock; all state updates on the rising edge.
- `reset_n  in  1` — asynchronous, active-low reset.
- `start  in  1` — launch the operation in `op`; sampled only when `busy`=0.
- `op  in  3` — operation select: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6 and 7 are no-ops.
- `srcA  in  32` — multiplicand, dividend, or mthi/mtlo data.
- `srcB  in  32` — multiplier or divisor.
- `cancel  in  1` — abort the in-flight operation (pipeline flush).
- `busy  out  1` — an operation is in progress.
- `done  out  1` — one-cycle pulse: HI/LO were just updated by mult or div.
- `hi  out  32` — HI register (remainder, or upper product).
- `lo  out  32` — LO register (quotient, or lower product).

## Operation

- **States.** IDLE, RUN, FIX. `reset_n`=0 forces IDLE and clears `hi`, `lo`, `busy`, `done`, the step counter and the working registers.
- **IDLE.**
  - `start` with op 4 writes `hi`←`srcA` at the edge. Op 5 does the same for `lo`. Neither asserts `busy`.
  - `start` with op 0–3 latches the operand magnitudes, the result signs and the op, clears the counter, and goes to RUN.
  - Magnitudes are the absolute values for signed ops and the raw values for unsigned ops. |0x80000000| is 0x80000000, interpreted as unsigned.
- **Divide by zero.** `start` with op 2/3 and `srcB`=0 is accepted but does not go to RUN. `hi` and `lo` stay unchanged, and `busy` and `done` stay 0.
- **RUN.** One step per cycle, 32 steps, counter 0..31.
  - Multiply: 64-bit accumulator {P,Q}. If Q[0] is set, P+mcand goes into a 33-bit sum; then shift right by 1.
  - Divide: restoring. Shift {R,Q} left by 1, form R−divisor in 33 bits, and if it is non-negative keep the difference and set Q[0].
  - After step 31, go to FIX.
- **FIX.** One cycle of sign correction, then write and return to IDLE.
  - Multiply: if the sign flag is set, negate the 64-bit product. Write `hi`←[63:32] and `lo`←[31:0].
  - Divide: negate the quotient if sign(A)≠sign(B). Negate the remainder if the dividend was negative. Write `lo`←quotient and `hi`←remainder.
  - Go to IDLE and pulse `done` in the following cycle.
- **Busy.** `start` while `busy`=1 is ignored. The hazard unit guarantees this never happens legally.
- **Cancel.** `cancel`=1 in RUN or FIX returns to IDLE at the next edge. `hi`/`lo` are not written and `done` is not pulsed.
  - `cancel` in IDLE is ignored.
  - When `start` and `cancel` arrive together in IDLE, `cancel` wins and nothing is launched.
- **Overflow.** −2^31 / −1 (div) yields `lo`=0x80000000 and `hi`=0. All arithmetic wraps modulo 2^32 per half.

## Timing

- Edge E: `start` accepted. From E+1 through E+33, `busy`=1 (32 RUN cycles plus 1 FIX cycle).
- HI/LO are visible after edge E+33. `done`=1 during the cycle after edge E+33, and `busy`=0 then.
- A new `start` is accepted on the edge ending the `done` cycle. Back-to-back issue period is 34 cycles.
- mthi/mtlo: value visible the cycle after the edge, no busy cycles.
- `busy` is a registered output and is derived directly from state ≠ IDLE.
- `done` is a registered output.
- `hi` and `lo` are outputs of the registers themselves; no combinational path exists from inputs to outputs.
- Asynchronous reset mid-RUN drops `busy` immediately and zeroes `hi`/`lo`. The operation is lost.

## Configuration

- `MDU_FAST_MULT_EN`
  - **Defined:** ops 0/1 bypass RUN. On the edge after `start` the block enters FIX with the product from a single-cycle 32×32 `*`. `busy` is high for exactly 1 cycle, and HI/LO are visible after edge E+1.
  - **Undefined:** the iterative path described above (33 busy cycles).
  - Divides are identical in both builds.

## Test plan

- **Signed multiply:** mult `srcA`=0xFFFFFFFF, `srcB`=2 → after 33 busy cycles, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE, `done` pulses once.
- **Unsigned multiply:** multu with the same operands → `hi`=0x00000001, `lo`=0xFFFFFFFE.
- **Signed divide, rounding and overflow:**
  - div 0xFFFFFFF9 (−7) by 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - div 0x80000000 by 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- **Divide by zero:** preload `hi`/`lo` via mthi 0x11 and mtlo 0x22, then divu 5 by 0 → `busy` stays 0, no `done`, `hi`=0x11 and `lo`=0x22 are retained.
- **Cancel:** start multu 3×4, assert `cancel` at busy cycle 10 → `busy` falls the next cycle, no `done`, HI/LO unchanged. A start issued the following cycle completes normally.
- **Ignored start and reset:**
  - `start` (mthi 0x55) during `busy` → ignored; `hi` becomes only the mult result.
  - `reset_n` pulsed low mid-RUN → `busy`, `hi`, `lo` all 0 immediately.
